if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- First pipeline stage of the scalar LoongArch core, directly upstream of the pre-decode stage.
- Holds the fetch PC and issues the instruction-RAM read for it; the RAM returns the word one cycle later, where pre-decode consumes it.
- Predicts the next PC with a direct-mapped BTB of 2-bit counters, trained by ID.
- Redirects on an ID branch cancel. Ready/valid handshake to pre-decode.

Parameters:
- RESET_PC, 32'h1C00_0000, first fetch address after reset.
- BTB_ENTRIES, 16, BTB entry count; power of 2, at least 2; index = pc[IDX+1:2], IDX = log2(BTB_ENTRIES).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- IPD_allow_in  in  1  pre-decode can accept this cycle
- br_taken_cancel  in  1  ID redirect: flush IF, restart at PC_fromID
- PC_fromID  in  32  redirect target; bits [1:0] are 0 by contract and are not checked
- bp_upd_valid  in  1  ID resolved a branch/jump this cycle
- bp_upd_pc  in  32  PC of the resolved instruction
- bp_upd_taken  in  1  actual direction
- bp_upd_target  in  32  actual taken target
- IF_to_IPD_valid  out  1  bus valid
- IF_to_IPD_bus  out  96  {pred_PC[95:64], inst_PC[63:32], 32'b0[31:0]}
- inst_ram_en  out  1  RAM read enable; RAM output holds when 0
- inst_ram_we  out  4  always 0
- inst_ram_addr  out  32  byte address
- inst_ram_wdata  out  32  always 0

Behaviour:
- Reset is synchronous and active-high on clk.
- State:
  - if_valid, reset 0.
  - if_pc, reset RESET_PC.
  - BTB: per entry valid, tag = pc[31:IDX+2], target[31:0], ctr[1:0]. Reset clears all valid bits; tag, target and ctr need no reset.
- Reset values of outputs: IF_to_IPD_valid=0, inst_ram_en=0, inst_ram_addr=RESET_PC.
- Startup: first cycle after reset deasserts, if_valid<=1 with if_pc=RESET_PC. Fetch therefore begins at RESET_PC one cycle after reset release.
- IF_ready_go=1.
- IF_to_IPD_valid = if_valid & ~br_taken_cancel.
- inst_ram_en = IF_to_IPD_valid & IPD_allow_in. inst_ram_addr = if_pc (combinational).
  - The RAM is read only in the transfer cycle.
  - While pre-decode stalls, en=0 so the RAM output keeps the word pre-decode is holding.
- Bus fields:
  - inst_PC = if_pc.
  - pred_PC = (hit & ctr[1]) ? target : if_pc+4, with 32-bit wrap.
  - hit = entry[if_pc idx].valid & tag match.
- Next-state priority, highest first:
  1. reset.
  2. br_taken_cancel: if_pc<=PC_fromID, if_valid<=1, regardless of IPD_allow_in. The current IF instruction is dropped: valid is masked and there is no RAM read.
  3. if_valid & IPD_allow_in: if_pc<=pred_PC.
  4. Otherwise hold.
- Redirect latency: the target is presented to pre-decode in the cycle after cancel, provided IPD_allow_in=1 in that cycle.
- BTB update, on bp_upd_valid, written at the clock edge:
  - Tag hit: ctr saturating +1 if taken, -1 if not; target<=bp_upd_target if taken.
  - Miss and taken: allocate (overwrite), valid=1, tag, target, ctr=2'b10.
  - Miss and not taken: no change.
- Same-cycle lookup and update of the same entry: the lookup sees the old contents (no bypass).
- Cancel and BTB update in the same cycle are independent and both take effect.
- Cancel during a pre-decode stall: the redirect takes effect; the new PC is held until IPD_allow_in.

Decomposition:
- Shared header gets:
  - IF_TO_IPD_BUS_WD = 96.
  - RESET_PC default.
  - BTB counter encodings: SNT=00, WNT=01, WT=10, ST=11.
- Sub-module: btb_dm, holding the BTB storage, a combinational lookup port (pc -> hit, ctr, target) and a synchronous update port. The top holds the PC, valid and handshake logic.

Test Plan:
- Reset release, IPD_allow_in=1, empty BTB -> valid from cycle 1; inst_PC 1C000000, 1C000004, 1C000008…; pred_PC = inst_PC+4; inst_ram_en=1 each cycle.
- IPD_allow_in=0 for 3 cycles at inst_PC 1C000008 -> valid stays 1, inst_ram_en=0, if_pc frozen; resumes with 1C00000C once allow_in=1.
- br_taken_cancel=1, PC_fromID=1C000100 while IF holds 1C00000C -> that cycle valid=0, en=0; next cycle inst_PC=1C000100.
- Two taken updates for pc=1C000010, target 1C000200 -> ctr 10→11; the next fetch of 1C000010 gives pred_PC=1C000200 and the following inst_PC=1C000200.
- Then two not-taken updates -> ctr 11→10→01; pred_PC=1C000014. Not-taken update to an unallocated pc -> BTB unchanged.
- Aliasing: pc 1C000010 allocated, then taken update for 1C000050 (same index, 16 entries) -> entry replaced; fetch of 1C000010 is a miss, pred_PC=1C000014.

Source files
------------

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: definitions shared by the fetch stage and its BTB.
//   IF_TO_IPD_BUS_WD   width of the IF -> pre-decode bus
//   RESET_PC_DEFAULT   default first fetch address
//   bp_ctr_e           2-bit direction counter encodings
//   bp_upd_t           branch resolution record sent back from ID
package if_stage_pkg;

    localparam int          IF_TO_IPD_BUS_WD = 96;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } bp_upd_t;

    // Saturating counter step toward the resolved direction.
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        n = c;
        if (taken) begin
            if (c != ST) n = c + 2'd1;
        end else begin
            if (c != SNT) n = c - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/if_stage_btb_dm.sv
// btb_dm: direct-mapped branch target buffer with 2-bit direction counters.
//   clk, reset           clock, synchronous active-high reset (clears valid bits)
//   lookup_pc[31:2]      fetch PC word address
//   hit, ctr, target     combinational lookup result (pre-update contents)
//   upd                  resolution from ID, written at the clock edge
module btb_dm
    import if_stage_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] lookup_pc,
    output logic        hit,
    output logic [1:0]  ctr,
    output logic [31:0] target,
    input  bp_upd_t     upd
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;

    assign lk_idx = lookup_pc[IDX+1:2];
    assign lk_tag = lookup_pc[31:IDX+2];
    assign up_idx = upd.pc[IDX+1:2];
    assign up_tag = upd.pc[31:IDX+2];

    assign hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign ctr    = ctr_q[lk_idx];
    assign target = target_q[lk_idx];

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    logic unused_upd_pc;
    assign unused_upd_pc = ^upd.pc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (upd.valid && !up_hit && upd.taken) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (!reset && upd.valid) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_step(ctr_q[up_idx], upd.taken);
                if (upd.taken) target_q[up_idx] <= upd.target;
            end else if (upd.taken) begin
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd.target;
                ctr_q[up_idx]    <= WT;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch. Holds the fetch PC, reads the instruction RAM
// in the transfer cycle and predicts the next PC through a direct-mapped BTB.
//   clk, reset               clock, synchronous active-high reset
//   IPD_allow_in             pre-decode can accept this cycle
//   br_taken_cancel          flush IF and restart at PC_fromID
//   bp_upd_*                 branch resolution from ID (BTB training)
//   IF_to_IPD_valid/_bus     {pred_PC, inst_PC, 32'b0} to pre-decode
//   inst_ram_*               instruction RAM read port (never writes)
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        IPD_allow_in,
    input  logic                        br_taken_cancel,
    input  logic [31:0]                 PC_fromID,
    input  logic                        bp_upd_valid,
    input  logic [31:0]                 bp_upd_pc,
    input  logic                        bp_upd_taken,
    input  logic [31:0]                 bp_upd_target,
    output logic                        IF_to_IPD_valid,
    output logic [IF_TO_IPD_BUS_WD-1:0] IF_to_IPD_bus,
    output logic                        inst_ram_en,
    output logic [3:0]                  inst_ram_we,
    output logic [31:0]                 inst_ram_addr,
    output logic [31:0]                 inst_ram_wdata
);

    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] pred_pc;
    logic        btb_hit;
    logic [1:0]  btb_ctr;
    logic [31:0] btb_target;
    bp_upd_t     upd;

    assign upd = '{valid: bp_upd_valid, pc: bp_upd_pc,
                   taken: bp_upd_taken, target: bp_upd_target};

    btb_dm #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk       (clk),
        .reset     (reset),
        .lookup_pc (if_pc[31:2]),
        .hit       (btb_hit),
        .ctr       (btb_ctr),
        .target    (btb_target),
        .upd       (upd)
    );

    assign pred_pc = (btb_hit && btb_ctr[1]) ? btb_target : if_pc + 32'd4;

    // A cancel kills the instruction currently in IF, so it never reaches
    // pre-decode and the RAM is not read for it.
    assign IF_to_IPD_valid = if_valid & ~br_taken_cancel;
    assign inst_ram_en     = IF_to_IPD_valid & IPD_allow_in;
    assign inst_ram_addr   = if_pc;
    assign inst_ram_we     = 4'b0;
    assign inst_ram_wdata  = 32'b0;
    assign IF_to_IPD_bus   = {pred_pc, if_pc, 32'b0};

    // if_valid rises the first cycle out of reset and stays high; IF always
    // holds an instruction to offer once running.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid <= 1'b0;
            if_pc    <= RESET_PC;
        end else begin
            if_valid <= 1'b1;
            if (br_taken_cancel)
                if_pc <= PC_fromID;
            else if (if_valid && IPD_allow_in)
                if_pc <= pred_pc;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IPD_allow_in = 1'b1;
    logic        br_taken_cancel = 1'b0;
    logic [31:0] PC_fromID = 32'h0;
    logic        bp_upd_valid = 1'b0;
    logic [31:0] bp_upd_pc = 32'h0;
    logic        bp_upd_taken = 1'b0;
    logic [31:0] bp_upd_target = 32'h0;
    logic        IF_to_IPD_valid;
    logic [95:0] IF_to_IPD_bus;
    logic        inst_ram_en;
    logic [3:0]  inst_ram_we;
    logic [31:0] inst_ram_addr;
    logic [31:0] inst_ram_wdata;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pred;
    } xfer_t;
    xfer_t sb[$];

    localparam logic [31:0] B = 32'h1C00_0000;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .IPD_allow_in    (IPD_allow_in),
        .br_taken_cancel (br_taken_cancel),
        .PC_fromID       (PC_fromID),
        .bp_upd_valid    (bp_upd_valid),
        .bp_upd_pc       (bp_upd_pc),
        .bp_upd_taken    (bp_upd_taken),
        .bp_upd_target   (bp_upd_target),
        .IF_to_IPD_valid (IF_to_IPD_valid),
        .IF_to_IPD_bus   (IF_to_IPD_bus),
        .inst_ram_en     (inst_ram_en),
        .inst_ram_we     (inst_ram_we),
        .inst_ram_addr   (inst_ram_addr),
        .inst_ram_wdata  (inst_ram_wdata)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted transfer must match the next expected word.
    always @(negedge clk) begin
        if (!reset && IF_to_IPD_valid && IPD_allow_in) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL xfer_unexpected inst=%h pred=%h", IF_to_IPD_bus[63:32], IF_to_IPD_bus[95:64]);
            end else begin
                xfer_t e;
                e = sb.pop_front();
                if (IF_to_IPD_bus !== {e.pred, e.inst, 32'b0} || inst_ram_en !== 1'b1) begin
                    fails++;
                    $display("FAIL xfer got inst=%h pred=%h en=%b want inst=%h pred=%h en=1",
                             IF_to_IPD_bus[63:32], IF_to_IPD_bus[95:64], inst_ram_en, e.inst, e.pred);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pred);
        sb.push_back('{inst: inst, pred: pred});
    endtask

    // Redirect while stalled: a single-cycle cancel, no checks.
    task automatic redirect(input logic [31:0] pc);
        br_taken_cancel = 1'b1;
        PC_fromID = pc;
        tick();
        br_taken_cancel = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        IPD_allow_in = 1'b1;
        repeat (2) begin
            @(negedge clk);
            tests++;
            if (IF_to_IPD_valid !== 1'b0 || inst_ram_en !== 1'b0 || inst_ram_addr !== B ||
                inst_ram_we !== 4'b0 || inst_ram_wdata !== 32'b0) begin
                fails++;
                $display("FAIL reset got valid=%b en=%b addr=%h we=%h wdata=%h want 0 0 %h 0 0",
                         IF_to_IPD_valid, inst_ram_en, inst_ram_addr, inst_ram_we, inst_ram_wdata, B);
            end
            tick();
        end
    endtask

    task automatic test_sequential();
        push(B, B + 4);
        push(B + 4, B + 8);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (IF_to_IPD_valid !== 1'b0) begin
            fails++;
            $display("FAIL startup_valid got %b want 0", IF_to_IPD_valid);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (inst_ram_addr !== B + 32'(4 * i) || inst_ram_en !== 1'b1) begin
                fails++;
                $display("FAIL seq_addr got %h en=%b want %h en=1", inst_ram_addr, inst_ram_en, B + 32'(4 * i));
            end
            tick();
        end
        IPD_allow_in = 1'b0;
    endtask

    task automatic test_stall();
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (IF_to_IPD_valid !== 1'b1 || inst_ram_en !== 1'b0 || inst_ram_addr !== B + 8) begin
                fails++;
                $display("FAIL stall got valid=%b en=%b addr=%h want 1 0 %h",
                         IF_to_IPD_valid, inst_ram_en, inst_ram_addr, B + 8);
            end
            tick();
        end
        push(B + 8, B + 12);
        IPD_allow_in = 1'b1;
        tick();
        @(negedge clk);
        tests++;
        if (inst_ram_addr !== B + 12) begin
            fails++;
            $display("FAIL stall_resume got %h want %h", inst_ram_addr, B + 12);
        end
    endtask

    task automatic test_cancel();
        br_taken_cancel = 1'b1;
        PC_fromID = B + 32'h100;
        @(negedge clk);
        tests++;
        if (IF_to_IPD_valid !== 1'b0 || inst_ram_en !== 1'b0) begin
            fails++;
            $display("FAIL cancel_mask got valid=%b en=%b want 0 0", IF_to_IPD_valid, inst_ram_en);
        end
        tick();
        br_taken_cancel = 1'b0;
        push(B + 32'h100, B + 32'h104);
        @(negedge clk);
        tests++;
        if (inst_ram_addr !== B + 32'h100) begin
            fails++;
            $display("FAIL cancel_target got %h want %h", inst_ram_addr, B + 32'h100);
        end
        tick();
        // Cancel during a stall: new PC held until allow_in.
        IPD_allow_in = 1'b0;
        br_taken_cancel = 1'b1;
        PC_fromID = B + 32'h300;
        tick();
        br_taken_cancel = 1'b0;
        repeat (2) begin
            @(negedge clk);
            tests++;
            if (IF_to_IPD_valid !== 1'b1 || inst_ram_en !== 1'b0 || inst_ram_addr !== B + 32'h300) begin
                fails++;
                $display("FAIL cancel_stall got valid=%b en=%b addr=%h want 1 0 %h",
                         IF_to_IPD_valid, inst_ram_en, inst_ram_addr, B + 32'h300);
            end
            tick();
        end
        push(B + 32'h300, B + 32'h304);
        IPD_allow_in = 1'b1;
        tick();
        IPD_allow_in = 1'b0;
    endtask

    task automatic test_btb_train();
        bp_upd_valid = 1'b1;
        bp_upd_pc = B + 32'h10;
        bp_upd_taken = 1'b1;
        bp_upd_target = B + 32'h200;
        tick();
        tick();
        bp_upd_valid = 1'b0;
        redirect(B + 32'h10);
        @(negedge clk);
        tests++;
        if (IF_to_IPD_bus[95:64] !== B + 32'h200) begin
            fails++;
            $display("FAIL train_pred got %h want %h", IF_to_IPD_bus[95:64], B + 32'h200);
        end
        push(B + 32'h10, B + 32'h200);
        push(B + 32'h200, B + 32'h204);
        IPD_allow_in = 1'b1;
        tick();
        @(negedge clk);
        tests++;
        if (inst_ram_addr !== B + 32'h200) begin
            fails++;
            $display("FAIL train_follow got %h want %h", inst_ram_addr, B + 32'h200);
        end
        tick();
        IPD_allow_in = 1'b0;
    endtask

    task automatic test_btb_untrain();
        redirect(B + 32'h10);
        bp_upd_valid = 1'b1;
        bp_upd_pc = B + 32'h10;
        bp_upd_taken = 1'b0;
        bp_upd_target = B + 32'h0F0;
        tick();
        // ctr now 10: still taken; second update's effect invisible until the edge.
        @(negedge clk);
        tests++;
        if (IF_to_IPD_bus[95:64] !== B + 32'h200) begin
            fails++;
            $display("FAIL untrain_nobypass got %h want %h", IF_to_IPD_bus[95:64], B + 32'h200);
        end
        tick();
        bp_upd_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (IF_to_IPD_bus[95:64] !== B + 32'h14) begin
            fails++;
            $display("FAIL untrain_pred got %h want %h", IF_to_IPD_bus[95:64], B + 32'h14);
        end
        // Not-taken on an empty entry must not allocate.
        bp_upd_valid = 1'b1;
        bp_upd_pc = B + 32'h20;
        bp_upd_taken = 1'b0;
        bp_upd_target = B + 32'h400;
        tick();
        bp_upd_valid = 1'b0;
        redirect(B + 32'h20);
        @(negedge clk);
        tests++;
        if (IF_to_IPD_bus[95:64] !== B + 32'h24) begin
            fails++;
            $display("FAIL nt_noalloc got %h want %h", IF_to_IPD_bus[95:64], B + 32'h24);
        end
    endtask

    task automatic test_alias();
        redirect(B + 32'h10);
        bp_upd_valid = 1'b1;
        bp_upd_pc = B + 32'h10;
        bp_upd_taken = 1'b1;
        bp_upd_target = B + 32'h200;
        tick();
        bp_upd_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (IF_to_IPD_bus[95:64] !== B + 32'h200) begin
            fails++;
            $display("FAIL alias_retrain got %h want %h", IF_to_IPD_bus[95:64], B + 32'h200);
        end
        // Cancel and aliasing allocation in the same cycle.
        br_taken_cancel = 1'b1;
        PC_fromID = B + 32'h50;
        bp_upd_valid = 1'b1;
        bp_upd_pc = B + 32'h50;
        bp_upd_taken = 1'b1;
        bp_upd_target = B + 32'h500;
        tick();
        br_taken_cancel = 1'b0;
        bp_upd_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (inst_ram_addr !== B + 32'h50 || IF_to_IPD_bus[95:64] !== B + 32'h500) begin
            fails++;
            $display("FAIL alias_alloc got addr=%h pred=%h want %h %h",
                     inst_ram_addr, IF_to_IPD_bus[95:64], B + 32'h50, B + 32'h500);
        end
        redirect(B + 32'h10);
        @(negedge clk);
        tests++;
        if (IF_to_IPD_bus[95:64] !== B + 32'h14) begin
            fails++;
            $display("FAIL alias_evict got %h want %h", IF_to_IPD_bus[95:64], B + 32'h14);
        end
        push(B + 32'h10, B + 32'h14);
        IPD_allow_in = 1'b1;
        tick();
        IPD_allow_in = 1'b0;
        @(negedge clk);
        tests++;
        if (inst_ram_addr !== B + 32'h14) begin
            fails++;
            $display("FAIL alias_follow got %h want %h", inst_ram_addr, B + 32'h14);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_cancel();
        test_btb_train();
        test_btb_untrain();
        test_alias();
        tick();
        tick();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog expired");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
